// File: rtl/branch_resolver.sv
// branch_resolver: EX-stage branch resolution; checks carried ID predictions, emits resolve events, redirects on mispredict.
//
// Optional feature: define BRANCH_RESOLVER_STATS_EN to build the resolve/mispredict counters.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   id_branch_i         branch in ID (pushed unless id_stall_i)
//   id_stall_i          ID held; suppresses push
//   id_predict_i        ID prediction (1 = taken)
//   id_pc_i, id_imm_i   branch PC and sign-extended halfword offset
//   ex_branch_i         branch in EX (pops head)
//   ex_alu_data_i       EX compare result; zero = taken
//   resolve_valid_o     resolve event this cycle
//   resolve_taken_o     actual outcome
//   mispredict_o        outcome differs from carried prediction
//   redirect_pc_o       correct next PC on mispredict, else 0
//   ifid_flush_o        flush IF/ID on mispredict
//   idex_flush_o        flush ID/EX on mispredict
//   error_o             sticky overflow/underflow flag
//   branch_cnt_o        resolved branch count (stats build)
//   mispred_cnt_o       mispredict count (stats build)
module branch_resolver #(
   parameter int DEPTH = 2,
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             id_branch_i,
   input  logic             id_stall_i,
   input  logic             id_predict_i,
   input  logic [31:0]      id_pc_i,
   input  logic [31:0]      id_imm_i,
   input  logic             ex_branch_i,
   input  logic [31:0]      ex_alu_data_i,
   output logic             resolve_valid_o,
   output logic             resolve_taken_o,
   output logic             mispredict_o,
   output logic [31:0]      redirect_pc_o,
   output logic             ifid_flush_o,
   output logic             idex_flush_o,
   output logic             error_o,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic          pred_q [DEPTH];
   logic [31:0]   tgt_q  [DEPTH];
   logic [31:0]   ft_q   [DEPTH];
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          err_q, err_d;
   logic          empty, full, push, pop, taken, do_push, do_pop, h_pred;
   logic [31:0]   h_tgt, h_ft;

   always_comb begin
      empty           = cnt_q == '0;
      full            = cnt_q == FULL;
      // An empty queue presents an all-zero head so underflow events still resolve.
      h_pred          = empty ? 1'b0 : pred_q[rd_q];
      h_tgt           = empty ? '0 : tgt_q[rd_q];
      h_ft            = empty ? '0 : ft_q[rd_q];
      taken           = ex_alu_data_i == '0;
      push            = id_branch_i & ~id_stall_i;
      pop             = ex_branch_i;
      resolve_valid_o = pop;
      resolve_taken_o = pop & taken;
      mispredict_o    = pop & (taken != h_pred);
      redirect_pc_o   = mispredict_o ? (taken ? h_tgt : h_ft) : '0;
      ifid_flush_o    = mispredict_o;
      idex_flush_o    = mispredict_o;
      do_pop          = pop & ~empty;
      // Wrong-path pushes are dropped on mispredict; a full queue only accepts alongside a real pop.
      do_push         = push & ~mispredict_o & (~full | do_pop);
      rd_d            = mispredict_o ? '0 : rd_q + PW'(do_pop);
      wr_d            = mispredict_o ? '0 : wr_q + PW'(do_push);
      cnt_d           = mispredict_o ? '0 : cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      err_d           = err_q | (push & full & ~pop) | (pop & empty);
      error_o         = err_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && do_push) begin
         pred_q[wr_q] <= id_predict_i;
         tgt_q[wr_q]  <= id_pc_i + (id_imm_i << 1);
         ft_q[wr_q]   <= id_pc_i + 32'd4;
      end
   end

`ifdef BRANCH_RESOLVER_STATS_EN
   logic [CNT_W-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;

   always_comb begin
      bcnt_d = bcnt_q + CNT_W'(pop);
      mcnt_d = mcnt_q + CNT_W'(mispredict_o);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bcnt_q <= '0;
         mcnt_q <= '0;
      end else begin
         bcnt_q <= bcnt_d;
         mcnt_q <= mcnt_d;
      end
   end

   assign branch_cnt_o  = bcnt_q;
   assign mispred_cnt_o = mcnt_q;
`else
   assign branch_cnt_o  = '0;
   assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed checks of branch_resolver outcomes, redirects, queue behaviour, error and counters.
module tb_branch_resolver;
`ifdef BRANCH_RESOLVER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        id_branch, id_stall, id_predict, ex_branch;
   logic [31:0] id_pc, id_imm, ex_alu;
   logic        resolve_valid, resolve_taken, mispredict, ifid_flush, idex_flush, error;
   logic [31:0] redirect_pc, branch_cnt, mispred_cnt;
   int          checks = 0;
   int          errors = 0;

   branch_resolver #(.DEPTH(2), .CNT_W(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .id_branch_i(id_branch), .id_stall_i(id_stall), .id_predict_i(id_predict),
      .id_pc_i(id_pc), .id_imm_i(id_imm),
      .ex_branch_i(ex_branch), .ex_alu_data_i(ex_alu),
      .resolve_valid_o(resolve_valid), .resolve_taken_o(resolve_taken),
      .mispredict_o(mispredict), .redirect_pc_o(redirect_pc),
      .ifid_flush_o(ifid_flush), .idex_flush_o(idex_flush),
      .error_o(error), .branch_cnt_o(branch_cnt), .mispred_cnt_o(mispred_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are sampled 1ns later, well away from the rising edge.
   task automatic step(input logic br, input logic st, input logic pr, input logic [31:0] pc,
                       input logic [31:0] imm, input logic ex, input logic [31:0] alu);
      @(negedge clk);
      id_branch = br; id_stall = st; id_predict = pr; id_pc = pc; id_imm = imm;
      ex_branch = ex; ex_alu = alu;
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1);
   endtask

   task automatic check_counts(input string tag, input int b, input int m);
      check({tag, "_bcnt"}, branch_cnt, STATS ? 32'(b) : 32'h0);
      check({tag, "_mcnt"}, mispred_cnt, STATS ? 32'(m) : 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      idle();
      @(negedge clk);
      rst = 1'b0;
      idle();
      check("rst_error", {31'b0, error}, 32'h0);
      check("rst_valid", {31'b0, resolve_valid}, 32'h0);
      check("rst_mispred", {31'b0, mispredict}, 32'h0);
      check("rst_redirect", redirect_pc, 32'h0);
      check_counts("rst", 0, 0);

      // Predicted not taken, actually taken: target 0x40 + 0x10.
      step(1'b1, 1'b0, 1'b0, 32'h40, 32'h8, 1'b0, 32'h1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
      check("t1_valid", {31'b0, resolve_valid}, 32'h1);
      check("t1_taken", {31'b0, resolve_taken}, 32'h1);
      check("t1_mispred", {31'b0, mispredict}, 32'h1);
      check("t1_redirect", redirect_pc, 32'h50);
      check("t1_flush", {30'b0, ifid_flush, idex_flush}, 32'h3);
      idle();
      check("t1_flush_clear", {30'b0, ifid_flush, idex_flush}, 32'h0);

      // Predicted taken, actually not taken: fall-through 0x104.
      step(1'b1, 1'b0, 1'b1, 32'h100, 32'h10, 1'b0, 32'h1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h5);
      check("t2_taken", {31'b0, resolve_taken}, 32'h0);
      check("t2_mispred", {31'b0, mispredict}, 32'h1);
      check("t2_redirect", redirect_pc, 32'h104);

      // A stalled ID branch must not enter the queue; then A resolves correctly while B pushes.
      step(1'b1, 1'b1, 1'b0, 32'h999, 32'h4, 1'b0, 32'h1);
      step(1'b1, 1'b0, 1'b1, 32'h200, 32'h20, 1'b0, 32'h1);
      step(1'b1, 1'b0, 1'b0, 32'h300, 32'hFFFF_FFFC, 1'b1, 32'h0);
      check("t3a_taken", {31'b0, resolve_taken}, 32'h1);
      check("t3a_mispred", {31'b0, mispredict}, 32'h0);
      check("t3a_flush", {30'b0, ifid_flush, idex_flush}, 32'h0);
      check("t3a_redirect", redirect_pc, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1);
      check("t3b_valid", {31'b0, resolve_valid}, 32'h1);
      check("t3b_mispred", {31'b0, mispredict}, 32'h0);
      idle();
      check("t3_no_error", {31'b0, error}, 32'h0);
      check_counts("t3", 4, 2);

      // Overflow: C and D fill the queue, E is dropped and flags the error.
      step(1'b1, 1'b0, 1'b0, 32'h1000, 32'h10, 1'b0, 32'h1);
      step(1'b1, 1'b0, 1'b1, 32'h2000, 32'h40, 1'b0, 32'h1);
      step(1'b1, 1'b0, 1'b1, 32'h3000, 32'h8, 1'b0, 32'h1);
      check("ovf_pre_error", {31'b0, error}, 32'h0);
      idle();
      check("ovf_error", {31'b0, error}, 32'h1);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1);
      check("ovf_c_mispred", {31'b0, mispredict}, 32'h0);
      idle();
      check_counts("five", 5, 2);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h7);
      check("ovf_d_mispred", {31'b0, mispredict}, 32'h1);
      check("ovf_d_redirect", redirect_pc, 32'h2004);
      idle();
      check_counts("ovf", 6, 3);

      // Reset clears the sticky error and counters.
      @(negedge clk);
      rst = 1'b1;
      idle();
      @(negedge clk);
      rst = 1'b0;
      idle();
      check("rst2_error", {31'b0, error}, 32'h0);
      check_counts("rst2", 0, 0);

      // Mispredict with a simultaneous push drops the push; the next EX branch underflows.
      step(1'b1, 1'b0, 1'b0, 32'h500, 32'h4, 1'b0, 32'h1);
      step(1'b1, 1'b0, 1'b1, 32'h600, 32'h4, 1'b1, 32'h0);
      check("t4_mispred", {31'b0, mispredict}, 32'h1);
      check("t4_redirect", redirect_pc, 32'h508);
      idle();
      check("t4_pre_error", {31'b0, error}, 32'h0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
      check("udf_valid", {31'b0, resolve_valid}, 32'h1);
      check("udf_mispred", {31'b0, mispredict}, 32'h1);
      check("udf_redirect", redirect_pc, 32'h0);
      idle();
      check("udf_error", {31'b0, error}, 32'h1);
      check_counts("udf", 2, 2);
      idle();
      idle();
      check("udf_error_sticky", {31'b0, error}, 32'h1);
      @(negedge clk);
      rst = 1'b1;
      idle();
      @(negedge clk);
      rst = 1'b0;
      idle();
      check("rst3_error", {31'b0, error}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
